// File: rtl/elliot_pkg.sv
// Shared types and helpers for the Elliot activation pipeline.
// Fixed-point one, saturating left shift and the outer FSM state encoding.
package elliot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    POST = 2'd3
  } state_t;

  function automatic logic [63:0] one_q(input int f);
    return 64'd1 << f;
  endfunction

  // Shift left arithmetically and clamp into a signed w-bit range.
  // The 128-bit working width leaves headroom for w + sh up to 126.
  function automatic logic signed [127:0] sat_shl(input logic signed [127:0] v,
                                                  input int w, input int sh);
    logic signed [127:0] p;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    p  = v <<< sh;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (p > hi) begin
      return hi;
    end else if (p < lo) begin
      return lo;
    end
    return p;
  endfunction

endpackage

// File: rtl/elliot_act_pipe_div.sv
// Sequential unsigned restoring divider producing QB fractional quotient bits
// of dividend/divisor; the caller guarantees dividend < divisor.
module seq_restoring_div #(
  parameter int DW = 31,
  parameter int VW = 32,
  parameter int QB = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [QB-1:0] quotient,
  output logic          last,
  output logic          done
);

  localparam int CW = (QB > 1) ? $clog2(QB) : 1;

  logic [VW-1:0] rem_reg;
  logic [VW-1:0] den_reg;
  logic [QB-1:0] q_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [VW:0]   shifted;
  logic          ge;

  always_comb begin
    shifted = {rem_reg, 1'b0};
    ge      = (shifted >= {1'b0, den_reg});
  end

  // High during the final step so the caller can leave its wait state on time.
  assign last     = busy_reg && (cnt_reg == '0);
  assign quotient = q_reg;
  assign done     = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      den_reg  <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !busy_reg) begin
        rem_reg  <= VW'(dividend);
        den_reg  <= divisor;
        q_reg    <= '0;
        cnt_reg  <= CW'(QB - 1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= ge ? VW'(shifted - {1'b0, den_reg}) : shifted[VW-1:0];
        q_reg   <= QB'({q_reg, ge});
        if (cnt_reg == '0) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elliot_act_pipe.sv
// Elliot activation y = s*x / (1 + |s*x|) with s = 2^STEEP, bipolar or unipolar,
// computed by a multi-cycle divider behind a start/busy/done handshake.
module elliot_act_pipe
  import elliot_pkg::*;
#(
  parameter int W     = 32,
  parameter int F     = 16,
  parameter int STEEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         unipolar,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] ONE_W = W'(one_q(F));
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  state_t              state_reg;
  logic signed [W-1:0] x_reg;
  logic                uni_reg;
  logic                neg_reg;
  logic [W-1:0]        y_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [W-1:0]        a_sat;
  logic [W-2:0]        mag;
  logic [W-1:0]        den;
  logic [W-1:0]        q_ext;
  logic [W-1:0]        ys;
  logic                div_start;
  logic                div_last;
  logic                div_done;
  logic [F-1:0]        q;

  // Magnitude of the most negative value clamps to the largest positive one.
  always_comb begin
    a_sat = W'(sat_shl(128'(x_reg), W, STEEP));
    if (!a_sat[W-1]) begin
      mag = a_sat[W-2:0];
    end else if (a_sat == MIN_W) begin
      mag = '1;
    end else begin
      mag = (~a_sat[W-2:0]) + 1'b1;
    end
    den   = ONE_W + {1'b0, mag};
    q_ext = {{(W-F){1'b0}}, q};
    ys    = neg_reg ? -q_ext : q_ext;
  end

  assign div_start = (state_reg == PREP);

  seq_restoring_div #(
    .DW(W-1),
    .VW(W),
    .QB(F)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(mag),
    .divisor (den),
    .quotient(q),
    .last    (div_last),
    .done    (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      uni_reg   <= 1'b0;
      neg_reg   <= 1'b0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg     <= x;
            uni_reg   <= unipolar;
            busy_reg  <= 1'b1;
            state_reg <= PREP;
          end
        end
        PREP: begin
          neg_reg   <= a_sat[W-1];
          state_reg <= DIV;
        end
        DIV: begin
          if (div_last) begin
            state_reg <= POST;
          end
        end
        POST: begin
          // ys + ONE is always in [1, 2*ONE), so the halving shift stays non-negative.
          if (div_done) begin
            y_reg    <= uni_reg ? ((ys + ONE_W) >> 1) : ys;
            done_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y    = y_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_elliot_act_pipe.sv
// Directed bench for elliot_act_pipe: W=32/F=16/STEEP=1 and W=16/F=8/STEEP=0 instances.
module tb_elliot_act_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, uni_a;
  logic [31:0] x_a, y_a;
  logic        busy_a, done_a;

  logic        start_b, uni_b;
  logic [15:0] x_b, y_b;
  logic        busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elliot_act_pipe #(.W(32), .F(16), .STEEP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .unipolar(uni_a),
    .x(x_a), .y(y_a), .busy(busy_a), .done(done_a)
  );

  elliot_act_pipe #(.W(16), .F(8), .STEEP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .unipolar(uni_b),
    .x(x_b), .y(y_b), .busy(busy_b), .done(done_b)
  );

  // Reference for the W=16, F=8, STEEP=0 instance.
  function automatic logic [15:0] ref_b(input logic [15:0] xv, input logic u);
    int a, mag, q, ys;
    a   = int'(signed'(xv));
    mag = (a < 0) ? -a : a;
    if (mag > 32767) mag = 32767;
    q   = (mag * 256) / (256 + mag);
    ys  = (a < 0) ? -q : q;
    if (u) ys = (ys + 256) >>> 1;
    return ys[15:0];
  endfunction

  // Called #1 after an edge; start is sampled at the next edge (E0).
  task automatic run_a(input logic [31:0] xv, input logic u,
                       output logic [31:0] yv, output int lat, output logic b0);
    x_a = xv; uni_a = u; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    b0 = busy_a;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_a) begin
        lat = n;
        break;
      end
    end
    yv = y_a;
    $display("op A x=%h uni=%0d y=%h latency=%0d", xv, u, yv, lat);
  endtask

  task automatic run_b(input logic [15:0] xv, input logic u,
                       output logic [15:0] yv, output int lat);
    x_b = xv; uni_b = u; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_b) begin
        lat = n;
        break;
      end
    end
    yv = y_b;
    $display("op B x=%h uni=%0d y=%h latency=%0d", xv, u, yv, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (y_a !== 32'h0)  begin $display("FAIL reset_y_a got %h want 0", y_a); n_err++; end
    n_cmp++;
    if (busy_a !== 1'b0) begin $display("FAIL reset_busy_a got %b want 0", busy_a); n_err++; end
    n_cmp++;
    if (done_a !== 1'b0) begin $display("FAIL reset_done_a got %b want 0", done_a); n_err++; end
    n_cmp++;
    if (y_b !== 16'h0)  begin $display("FAIL reset_y_b got %h want 0", y_b); n_err++; end
    n_cmp++;
    if (busy_b !== 1'b0) begin $display("FAIL reset_busy_b got %b want 0", busy_b); n_err++; end
    n_cmp++;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_bipolar();
    logic [31:0] yv; int lat; logic b0;
    run_a(32'h0001_0000, 1'b0, yv, lat, b0);
    if (yv !== 32'd43690) begin $display("FAIL bip_one got %h want %h", yv, 32'd43690); n_err++; end
    n_cmp++;
    if (lat !== 18) begin $display("FAIL bip_latency got %0d want 18", lat); n_err++; end
    n_cmp++;
    if (b0 !== 1'b1) begin $display("FAIL busy_after_start got %b want 1", b0); n_err++; end
    n_cmp++;
    run_a(32'hFFFF_0000, 1'b0, yv, lat, b0);
    if (yv !== 32'hFFFF_5556) begin $display("FAIL bip_minus_one got %h want FFFF5556", yv); n_err++; end
    n_cmp++;
    repeat (3) @(posedge clk);
    #1;
    if (y_a !== 32'hFFFF_5556 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      $display("FAIL hold_after_done got y=%h done=%b busy=%b want FFFF5556/0/0", y_a, done_a, busy_a);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_zero_unipolar();
    logic [31:0] yv; int lat; logic b0;
    run_a(32'h0, 1'b0, yv, lat, b0);
    if (yv !== 32'h0) begin $display("FAIL zero_bip got %h want 0", yv); n_err++; end
    n_cmp++;
    run_a(32'h0, 1'b1, yv, lat, b0);
    if (yv !== 32'h0000_8000) begin $display("FAIL zero_uni got %h want 00008000", yv); n_err++; end
    n_cmp++;
    run_a(32'h0001_0000, 1'b1, yv, lat, b0);
    if (yv !== 32'd54613) begin $display("FAIL one_uni got %h want %h", yv, 32'd54613); n_err++; end
    n_cmp++;
  endtask

  task automatic test_saturation();
    logic [31:0] yv; int lat; logic b0;
    run_a(32'h7FFF_FFFF, 1'b0, yv, lat, b0);
    if (yv !== 32'd65534) begin $display("FAIL sat_pos got %h want %h", yv, 32'd65534); n_err++; end
    n_cmp++;
    run_a(32'h8000_0000, 1'b0, yv, lat, b0);
    if (yv !== 32'hFFFF_0002) begin $display("FAIL sat_neg got %h want FFFF0002", yv); n_err++; end
    n_cmp++;
    run_a(32'h8000_0000, 1'b1, yv, lat, b0);
    if (yv !== 32'd1) begin $display("FAIL sat_neg_uni got %h want 1", yv); n_err++; end
    n_cmp++;
    run_a(32'h7FFF_FFFF, 1'b1, yv, lat, b0);
    if (yv !== 32'd65535) begin $display("FAIL sat_pos_uni got %h want %h", yv, 32'd65535); n_err++; end
    n_cmp++;
  endtask

  // Extra starts at E3 and E10 (with different x/unipolar) must be ignored.
  task automatic test_ignored_start();
    int dones, done_at;
    x_a = 32'h0001_0000; uni_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dones = 0; done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3 || n == 10) begin
        start_a = 1'b1; x_a = 32'h7FFF_FFFF; uni_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
    end
    $display("op A ignored-start dones=%0d first_done=%0d y=%h", dones, done_at, y_a);
    if (dones !== 1) begin $display("FAIL ignored_start_count got %0d want 1", dones); n_err++; end
    n_cmp++;
    if (done_at !== 18) begin $display("FAIL ignored_start_latency got %0d want 18", done_at); n_err++; end
    n_cmp++;
    if (y_a !== 32'd43690) begin $display("FAIL ignored_start_y got %h want %h", y_a, 32'd43690); n_err++; end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int first, gap;
    x_a = 32'h0001_0000; uni_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_a) begin
        first = n;
        break;
      end
    end
    if (first !== 18) begin $display("FAIL b2b_first_latency got %0d want 18", first); n_err++; end
    n_cmp++;
    // Start presented during the done cycle.
    x_a = 32'hFFFF_0000; start_a = 1'b1;
    gap = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a) begin
        gap = n;
        break;
      end
    end
    $display("op A back-to-back gap=%0d y=%h", gap, y_a);
    if (gap !== 19) begin $display("FAIL b2b_gap got %0d want 19", gap); n_err++; end
    n_cmp++;
    if (y_a !== 32'hFFFF_5556) begin $display("FAIL b2b_y got %h want FFFF5556", y_a); n_err++; end
    n_cmp++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] yv; int lat; logic b0; int dones;
    x_a = 32'h0001_0000; uni_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || y_a !== 32'h0) begin
      $display("FAIL abort_state got busy=%b done=%b y=%h want 0/0/0", busy_a, done_a, y_a);
      n_err++;
    end
    n_cmp++;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    $display("op A reset-abort late dones=%0d", dones);
    if (dones !== 0) begin $display("FAIL abort_no_done got %0d want 0", dones); n_err++; end
    n_cmp++;
    run_a(32'hFFFF_0000, 1'b0, yv, lat, b0);
    if (yv !== 32'hFFFF_5556 || lat !== 18) begin
      $display("FAIL abort_fresh got y=%h lat=%0d want FFFF5556/18", yv, lat);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_small_config();
    logic [15:0] yv, xv, exp_y; int lat; logic u;
    run_b(16'h0100, 1'b0, yv, lat);
    if (yv !== 16'h0080) begin $display("FAIL small_half got %h want 0080", yv); n_err++; end
    n_cmp++;
    if (lat !== 10) begin $display("FAIL small_latency got %0d want 10", lat); n_err++; end
    n_cmp++;
    run_b(16'h8000, 1'b0, yv, lat);
    if (yv !== 16'hFF02) begin $display("FAIL small_min got %h want FF02", yv); n_err++; end
    n_cmp++;
    for (int i = 0; i < 12; i++) begin
      xv = 16'($urandom);
      u  = 1'($urandom_range(0, 1));
      exp_y = ref_b(xv, u);
      run_b(xv, u, yv, lat);
      if (yv !== exp_y) begin
        $display("FAIL small_sweep x=%h uni=%0d got %h want %h", xv, u, yv, exp_y);
        n_err++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; uni_a = 1'b0; x_a = '0;
    start_b = 1'b0; uni_b = 1'b0; x_b = '0;
    test_reset();
    test_bipolar();
    test_zero_unipolar();
    test_saturation();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
